// File: rtl/data_ram.sv
// Single-port byte-addressable data RAM with a valid/ready request port and a strobed response.
// Define DATA_RAM_BOUNDS_CHECK_EN to flag addresses beyond DEPTH_BYTES instead of wrapping them.
module data_ram #(
    parameter int unsigned DEPTH_BYTES = 65536,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int unsigned Words = DEPTH_BYTES / 4;
    localparam int unsigned IdxW  = (Words > 1) ? $clog2(Words) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        write_q, uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;
    logic        accept, commit, misaligned, out_of_range, err, do_write;
    logic [31:0] word_addr, rword, load_sh, load_data, wdata_sh;
    logic [IdxW-1:0] idx;
    logic [4:0]  shamt;
    logic [3:0]  be;

    // Zero at configuration; never cleared by reset.
    logic [31:0] mem [Words] = '{default: '0};

    assign req_ready = (state_q == StIdle);
    assign accept    = req_valid & req_ready;
    assign commit    = (state_q == StResp);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d    = StWait;
                        wait_cnt_d = 4'(WAIT_STATES - 1);
                    end
                end
            end
            StWait: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        misaligned = (size_q == 2'd3) ||
                     (size_q == 2'd1 && addr_q[0]) ||
                     (size_q == 2'd2 && addr_q[1:0] != 2'b00);
`ifdef DATA_RAM_BOUNDS_CHECK_EN
        // Aligned accesses never straddle the end, so the base address covers every byte.
        out_of_range = (addr_q >= DEPTH_BYTES);
`else
        out_of_range = 1'b0;
`endif
        err       = misaligned | out_of_range;
        word_addr = addr_q >> 2;
        idx       = IdxW'(word_addr & (Words - 1));
        shamt     = {addr_q[1:0], 3'b000};
        rword     = mem[idx];
        load_sh   = rword >> shamt;
        wdata_sh  = wdata_q << shamt;
        load_data = rword;
        be        = 4'b0000;
        case (size_q)
            2'd0: begin
                load_data = uns_q ? {24'd0, load_sh[7:0]} : {{24{load_sh[7]}}, load_sh[7:0]};
                be        = 4'b0001 << addr_q[1:0];
            end
            2'd1: begin
                load_data = uns_q ? {16'd0, load_sh[15:0]} : {{16{load_sh[15]}}, load_sh[15:0]};
                be        = 4'b0011 << addr_q[1:0];
            end
            2'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        do_write = commit & write_q & ~err;
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            wait_cnt_q <= 4'd0;
            write_q    <= 1'b0;
            size_q     <= 2'd0;
            uns_q      <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_error <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            resp_valid <= commit;
            if (accept) begin
                write_q <= req_write;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (commit) begin
                resp_rdata <= (err | write_q) ? 32'd0 : load_data;
                resp_error <= err;
            end
        end
    end

endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram: a WAIT_STATES=0, 1 KiB instance driven from a vector table and a
// WAIT_STATES=3 instance exercising timing and mid-transaction reset.
module tb_data_ram;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_valid = 1'b0, a_ready, a_write = 1'b0, a_uns = 1'b0;
    logic [1:0]  a_size = 2'd0;
    logic [31:0] a_addr = 32'd0, a_wdata = 32'd0, a_rdata;
    logic        a_rvalid, a_err;

    logic        b_valid = 1'b0, b_ready, b_write = 1'b0, b_uns = 1'b0;
    logic [1:0]  b_size = 2'd0;
    logic [31:0] b_addr = 32'd0, b_wdata = 32'd0, b_rdata;
    logic        b_rvalid, b_err;

    data_ram #(.DEPTH_BYTES(1024), .WAIT_STATES(0)) u_dut_a (
        .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
        .req_size(a_size), .req_unsigned(a_uns), .req_addr(a_addr), .req_wdata(a_wdata),
        .resp_valid(a_rvalid), .resp_rdata(a_rdata), .resp_error(a_err)
    );

    data_ram #(.DEPTH_BYTES(65536), .WAIT_STATES(3)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
        .req_size(b_size), .req_unsigned(b_uns), .req_addr(b_addr), .req_wdata(b_wdata),
        .resp_valid(b_rvalid), .resp_rdata(b_rdata), .resp_error(b_err)
    );

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns lat = edges from accept edge (1) to response edge.
    task automatic txn_a(input logic wr, input logic [1:0] sz, input logic un,
                         input logic [31:0] ad, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat);
        int guard = 0;
        while (!a_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        a_valid = 1'b1; a_write = wr; a_size = sz; a_uns = un; a_addr = ad; a_wdata = wd;
        @(posedge clk); #1;
        a_valid = 1'b0;
        lat = 1;
        rd = 32'hx; er = 1'bx;
        while (lat < 50) begin
            @(posedge clk); #1; lat++;
            if (a_rvalid) begin
                rd = a_rdata; er = a_err;
                break;
            end
        end
        if (lat >= 50) lat = -1;
    endtask

    task automatic txn_b(input logic wr, input logic [1:0] sz, input logic un,
                         input logic [31:0] ad, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat,
                         output int rlow);
        int guard = 0;
        while (!b_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        b_valid = 1'b1; b_write = wr; b_size = sz; b_uns = un; b_addr = ad; b_wdata = wd;
        @(posedge clk); #1;
        lat = 1;
        rlow = b_ready ? 0 : 1;
        rd = 32'hx; er = 1'bx;
        // valid stays high through the whole transaction; only one request may be accepted
        while (lat < 50) begin
            @(posedge clk); #1; lat++;
            if (b_rvalid) begin
                rd = b_rdata; er = b_err;
                break;
            end
            if (!b_ready) rlow++;
        end
        b_valid = 1'b0;
        if (lat >= 50) lat = -1;
    endtask

    vec_t        vecs[17];
    logic [31:0] rd;
    logic        er;
    int          lat, rlow, seen;

    initial begin
        vecs[0]  = '{"sw_10",    1, 2'd2, 0, 32'h10,  32'h8899AABB, 0, 32'h0,        0};
        vecs[1]  = '{"lb_11",    0, 2'd0, 0, 32'h11,  32'h0,        1, 32'hFFFFFFAA, 0};
        vecs[2]  = '{"lhu_12",   0, 2'd1, 1, 32'h12,  32'h0,        1, 32'h00008899, 0};
        vecs[3]  = '{"lh_12",    0, 2'd1, 0, 32'h12,  32'h0,        1, 32'hFFFF8899, 0};
        vecs[4]  = '{"lbu_13",   0, 2'd0, 1, 32'h13,  32'h0,        1, 32'h00000088, 0};
        vecs[5]  = '{"lw_10",    0, 2'd2, 1, 32'h10,  32'h0,        1, 32'h8899AABB, 0};
        vecs[6]  = '{"sb_21",    1, 2'd0, 0, 32'h21,  32'h123456FF, 0, 32'h0,        0};
        vecs[7]  = '{"lw_20",    0, 2'd2, 0, 32'h20,  32'h0,        1, 32'h0000FF00, 0};
        vecs[8]  = '{"lw_02",    0, 2'd2, 0, 32'h02,  32'h0,        1, 32'h0,        1};
        vecs[9]  = '{"sh_03",    1, 2'd1, 0, 32'h03,  32'h0000FFFF, 1, 32'h0,        1};
        vecs[10] = '{"size3",    1, 2'd3, 0, 32'h10,  32'hFFFFFFFF, 1, 32'h0,        1};
        vecs[11] = '{"lw_10_b",  0, 2'd2, 0, 32'h10,  32'h0,        1, 32'h8899AABB, 0};
        vecs[12] = '{"lw_00",    0, 2'd2, 0, 32'h00,  32'h0,        1, 32'h0,        0};
        vecs[13] = '{"sh_22",    1, 2'd1, 0, 32'h22,  32'hABCDBEEF, 0, 32'h0,        0};
        vecs[14] = '{"lw_20_b",  0, 2'd2, 0, 32'h20,  32'h0,        1, 32'hBEEFFF00, 0};
        vecs[15] = '{"sw_00",    1, 2'd2, 0, 32'h00,  32'h11223344, 0, 32'h0,        0};
`ifdef DATA_RAM_BOUNDS_CHECK_EN
        vecs[16] = '{"lw_400",   0, 2'd2, 0, 32'h400, 32'h0,        1, 32'h0,        1};
`else
        vecs[16] = '{"lw_400",   0, 2'd2, 0, 32'h400, 32'h0,        1, 32'h11223344, 0};
`endif

        repeat (2) @(posedge clk);
        #1;
        check("rst_resp_valid", {31'd0, a_rvalid}, 32'd0);
        check("rst_rdata", a_rdata, 32'd0);
        check("rst_error", {31'd0, a_err}, 32'd0);
        rst = 1'b0;
        check("ready_after_rst", {31'd0, a_ready}, 32'd1);

        for (int i = 0; i < 17; i++) begin
            txn_a(vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            check({vecs[i].name, "_lat"}, lat, 2);
            check({vecs[i].name, "_err"}, {31'd0, er}, {31'd0, vecs[i].exp_err});
            if (vecs[i].chk_rd) check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
        end
        txn_a(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, rd, er, lat);
        check("lw_00_after", rd, 32'h11223344);
        // Outputs hold between responses.
        @(posedge clk); #1;
        check("hold_rdata", a_rdata, 32'h11223344);
        check("hold_valid", {31'd0, a_rvalid}, 32'd0);

        // Wait-state instance: timing and ready profile.
        txn_b(1'b1, 2'd2, 1'b0, 32'h40, 32'hA5A5A5A5, rd, er, lat, rlow);
        check("b_sw_lat", lat, 5);
        check("b_sw_ready_low", rlow, 4);
        txn_b(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, rd, er, lat, rlow);
        check("b_lw_lat", lat, 5);
        check("b_lw_ready_low", rlow, 4);
        check("b_lw_rdata", rd, 32'hA5A5A5A5);

        // Reset while a store sits in WAIT: must be dropped.
        b_valid = 1'b1; b_write = 1'b1; b_size = 2'd2; b_addr = 32'h30; b_wdata = 32'h12345678;
        @(posedge clk); #1;
        b_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, b_rvalid}, 32'd0);
        check("mid_rst_rdata", b_rdata, 32'd0);
        check("mid_rst_a_rdata", a_rdata, 32'd0);
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (b_rvalid) seen++;
        end
        rst = 1'b0;
        check("dropped_no_resp", seen, 0);
        check("b_ready_post_rst", {31'd0, b_ready}, 32'd1);
        txn_b(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, rd, er, lat, rlow);
        check("b_lw30_lat", lat, 5);
        check("b_lw30_rdata", rd, 32'h00000000);
        check("b_lw30_err", {31'd0, er}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
